led_stripe_bit_receiver: RTL and testbench

//  Receive end of the single-wire LED stripe protocol driven by bit_transmitter.

---
 rtl/led_stripe_bit_receiver.sv | 178 +++++++++++++++++
 tb/tb_led_stripe_bit_receiver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_stripe_bit_receiver.sv
// Receive side of the single-wire LED stripe: measures high-pulse widths,
// decodes bits into 24-bit pixels (MSB first), detects the frame reset gap
// and regenerates the line for the next LED after absorbing the first pixel.
module led_stripe_bit_receiver #(
  parameter logic [15:0] L_TIME = 16'd80,
  parameter logic [15:0] S_TIME = 16'd40,
  parameter logic [15:0] R_TIME = 16'd150
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        din,
  output logic [23:0] pixel_data,
  output logic        pixel_valid,
  output logic        frame_end,
  output logic [15:0] pixel_count,
  output logic        err,
  output logic        dout
);

  localparam logic [15:0] THRESH   = (L_TIME + S_TIME) / 16'd2;
  localparam logic [15:0] MIN_HIGH = S_TIME / 16'd2;
  localparam logic [15:0] MAX_HIGH = 16'd2 * L_TIME;
  localparam logic [15:0] STUCK    = MAX_HIGH + 16'd1;

  typedef enum logic [1:0] {WAIT_RST, READY, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic        din_meta_q, din_s_q, din_d_q;
  logic [15:0] high_cnt_q, high_cnt_d;
  logic [15:0] low_cnt_q, low_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [23:0] pixel_data_q, pixel_data_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic        frame_end_q, frame_end_d;
  logic [15:0] pixel_count_q, pixel_count_d;
  logic        err_q, err_d;
  logic        fwd_en_q, fwd_en_d;
  logic        dout_q, dout_d;
  logic        rise, fall, new_bit;

  assign rise = din_s_q & ~din_d_q;
  assign fall = din_d_q & ~din_s_q;

  // Two-flop synchronizer for the asynchronous line plus an edge-detect delay stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_meta_q <= 1'b0;
      din_s_q    <= 1'b0;
      din_d_q    <= 1'b0;
    end else begin
      din_meta_q <= din;
      din_s_q    <= din_meta_q;
      din_d_q    <= din_s_q;
    end
  end

  // Level-width counters: high restarts at 1 on a rise, low restarts at 1 on a fall; both saturate.
  always_comb begin
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    if (din_s_q) begin
      low_cnt_d = '0;
      if (rise)                       high_cnt_d = 16'd1;
      else if (high_cnt_q != 16'hFFFF) high_cnt_d = high_cnt_q + 16'd1;
    end else begin
      if (fall)                       low_cnt_d = 16'd1;
      else if (low_cnt_q != 16'hFFFF) low_cnt_d = low_cnt_q + 16'd1;
    end
  end

  // Protocol FSM: decodes bits, assembles pixels, flags errors and the frame gap.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    frame_end_d   = 1'b0;
    err_d         = 1'b0;
    pixel_count_d = frame_end_q ? 16'd0 : pixel_count_q;
    fwd_en_d      = fwd_en_q;
    new_bit       = (high_cnt_q >= THRESH);
    case (state_q)
      WAIT_RST: begin
        if (low_cnt_q >= R_TIME) state_d = rise ? HIGH : READY;
      end
      READY: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          if (high_cnt_q < MIN_HIGH) begin
            err_d     = 1'b1;
            state_d   = WAIT_RST;
            shift_d   = '0;
            bit_cnt_d = '0;
            fwd_en_d  = 1'b0;
          end else begin
            shift_d = {shift_q[22:0], new_bit};
            state_d = LOW;
            if (bit_cnt_q == 5'd23) begin
              pixel_data_d  = {shift_q[22:0], new_bit};
              pixel_valid_d = 1'b1;
              shift_d       = '0;
              bit_cnt_d     = '0;
              if (pixel_count_q == 16'd0)     fwd_en_d      = 1'b1;
              if (pixel_count_q != 16'hFFFF) pixel_count_d = pixel_count_q + 16'd1;
            end else begin
              bit_cnt_d = bit_cnt_q + 5'd1;
            end
          end
        end else if (din_s_q && high_cnt_d == STUCK) begin
          err_d     = 1'b1;
          state_d   = WAIT_RST;
          shift_d   = '0;
          bit_cnt_d = '0;
          fwd_en_d  = 1'b0;
        end
      end
      LOW: begin
        if (low_cnt_q == R_TIME) begin
          frame_end_d = 1'b1;
          fwd_en_d    = 1'b0;
          state_d     = rise ? HIGH : READY;
          if (bit_cnt_q != 5'd0) begin
            err_d     = 1'b1;
            shift_d   = '0;
            bit_cnt_d = '0;
          end
        end else if (rise) begin
          state_d = HIGH;
        end
      end
      default: state_d = WAIT_RST;
    endcase
    dout_d = fwd_en_q & din_s_q;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= WAIT_RST;
      high_cnt_q    <= '0;
      low_cnt_q     <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      frame_end_q   <= 1'b0;
      pixel_count_q <= '0;
      err_q         <= 1'b0;
      fwd_en_q      <= 1'b0;
      dout_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      high_cnt_q    <= high_cnt_d;
      low_cnt_q     <= low_cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      frame_end_q   <= frame_end_d;
      pixel_count_q <= pixel_count_d;
      err_q         <= err_d;
      fwd_en_q      <= fwd_en_d;
      dout_q        <= dout_d;
    end
  end

  assign pixel_data  = pixel_data_q;
  assign pixel_valid = pixel_valid_q;
  assign frame_end   = frame_end_q;
  assign pixel_count = pixel_count_q;
  assign err         = err_q;
  assign dout        = dout_q;

endmodule

// File: tb/tb_led_stripe_bit_receiver.sv
// Scoreboard bench for led_stripe_bit_receiver: stimulus pushes expected
// pixels and frame ends, a negedge monitor pops and compares them.
module tb_led_stripe_bit_receiver;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        frame_end;
  logic [15:0] pixel_count;
  logic        err;
  logic        dout;

  led_stripe_bit_receiver dut (
    .clk(clk), .rstn(rstn), .din(din),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .frame_end(frame_end),
    .pixel_count(pixel_count), .err(err), .dout(dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cnt; bit errExp; } frame_t;

  logic [23:0] pixQ[$];
  frame_t      frameQ[$];
  int testsRun = 0;
  int testsFailed = 0;
  int errCount = 0;
  int doutHighCount = 0;
  int doutRiseCyc = -1;
  int firstErrCyc = -1;
  bit doutArm = 1'b0;
  bit checkClear = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: pops expected pixels/frame ends as the DUT presents them and tallies err/dout.
  always @(negedge clk) begin
    frame_t f;
    if (checkClear) begin
      checkOutput("countClear", {16'd0, pixel_count}, 32'd0);
      checkClear = 1'b0;
    end
    if (pixel_valid) begin
      if (pixQ.size() == 0) begin
        testsRun++; testsFailed++;
        $display("[TB] FAIL unexpectedPixel: got %0h expected none", pixel_data);
      end else begin
        checkOutput("pixelData", {8'd0, pixel_data}, {8'd0, pixQ.pop_front()});
      end
    end
    if (frame_end) begin
      if (frameQ.size() == 0) begin
        testsRun++; testsFailed++;
        $display("[TB] FAIL unexpectedFrameEnd: got 1 expected 0");
      end else begin
        f = frameQ.pop_front();
        checkOutput("frameCount", {16'd0, pixel_count}, f.cnt);
        checkOutput("frameErr", {31'd0, err}, {31'd0, f.errExp});
        checkClear = 1'b1;
      end
    end
    if (err) begin
      errCount++;
      if (firstErrCyc < 0) firstErrCyc = cyc;
    end
    if (dout) begin
      doutHighCount++;
      if (doutArm && doutRiseCyc < 0) doutRiseCyc = cyc;
    end
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] timeout");
  end

  task automatic drive(input logic level, input int n);
    din = level;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  // Sends bits px[topBit] down through nbits bits; returns total high time sent.
  task automatic applyStimulus(input logic [23:0] px, input int topBit, input int nbits,
                               input bit exact, output int highSum);
    int hi;
    int lo;
    highSum = 0;
    for (int i = topBit; i > topBit - nbits; i--) begin
      if (exact) begin
        hi = px[i] ? 80 : 40;
        lo = px[i] ? 40 : 80;
      end else begin
        hi = px[i] ? int'($urandom_range(120, 65)) : int'($urandom_range(55, 21));
        lo = int'($urandom_range(70, 40));
      end
      highSum += hi;
      sendBit(hi, lo);
    end
  endtask

  task automatic sendPixel(input logic [23:0] px, input bit exact, input bit accepted, output int highSum);
    if (accepted) pixQ.push_back(px);
    applyStimulus(px, 23, 24, exact, highSum);
  endtask

  task automatic endFrame(input int cnt, input bit errExp);
    frame_t f;
    f.cnt = cnt;
    f.errExp = errExp;
    frameQ.push_back(f);
    drive(1'b0, 160);
  endtask

  task automatic checkQueues(input string tag);
    checkOutput({tag, "_pixQ"}, pixQ.size(), 32'd0);
    checkOutput({tag, "_frameQ"}, frameQ.size(), 32'd0);
  endtask

  // Sequenced scenarios: reset, exact pixels, forwarding, thresholds, errors, mid-pixel reset, random frames.
  initial begin
    int fh, fh2, e0, riseCyc, dinRiseCyc, expFwd, n;
    logic [31:0] r;
    logic [23:0] px;

    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstFlags", {28'd0, pixel_valid, frame_end, err, dout}, 32'd0);
    checkOutput("rstData", {8'd0, pixel_data}, 32'd0);
    checkOutput("rstCount", {16'd0, pixel_count}, 32'd0);
    rstn = 1'b1;

    // T1
    drive(1'b0, 150);
    e0 = errCount;
    doutHighCount = 0;
    sendPixel(24'hA5C3F0, 1'b1, 1'b1, fh);
    endFrame(1, 1'b0);
    checkQueues("t1");
    checkOutput("t1Err", errCount - e0, 32'd0);
    checkOutput("t1Dout", doutHighCount, 32'd0);

    // T2
    e0 = errCount;
    doutHighCount = 0;
    sendPixel(24'h112233, 1'b1, 1'b1, fh);
    doutRiseCyc = -1;
    doutArm = 1'b1;
    dinRiseCyc = cyc;
    sendPixel(24'hFFEE00, 1'b1, 1'b1, fh2);
    endFrame(2, 1'b0);
    doutArm = 1'b0;
    checkQueues("t2");
    checkOutput("t2DoutHigh", doutHighCount, fh2);
    checkOutput("t2DoutLatency", doutRiseCyc, dinRiseCyc + 3);
    checkOutput("t2Err", errCount - e0, 32'd0);

    // T3
    e0 = errCount;
    doutHighCount = 0;
    r = $urandom;
    px = {2'b01, r[21:0]};
    pixQ.push_back(px);
    sendBit(59, 60);
    sendBit(60, 60);
    applyStimulus(px, 21, 22, 1'b0, fh);
    endFrame(1, 1'b0);
    checkQueues("t3");
    checkOutput("t3Dout", doutHighCount, 32'd0);
    checkOutput("t3Err", errCount - e0, 32'd0);

    // T4
    e0 = errCount;
    r = $urandom;
    applyStimulus(r[23:0], 23, 10, 1'b0, fh);
    endFrame(0, 1'b1);
    r = $urandom;
    sendPixel(r[23:0], 1'b0, 1'b1, fh);
    endFrame(1, 1'b0);
    checkQueues("t4");
    checkOutput("t4Err", errCount - e0, 32'd1);

    // T5: err registers after the 161st synchronized-high cycle (line reaches din_s two edges after din).
    e0 = errCount;
    firstErrCyc = -1;
    riseCyc = cyc;
    drive(1'b1, 200);
    drive(1'b0, 60);
    checkOutput("t5StuckCyc", firstErrCyc, riseCyc + 163);
    r = $urandom;
    sendPixel(r[23:0], 1'b0, 1'b0, fh);
    drive(1'b0, 160);
    checkOutput("t5StuckErr", errCount - e0, 32'd1);
    sendBit(15, 60);
    drive(1'b0, 160);
    checkOutput("t5GlitchErr", errCount - e0, 32'd2);
    checkQueues("t5");

    // T6
    e0 = errCount;
    r = $urandom;
    applyStimulus(r[23:0], 23, 12, 1'b0, fh);
    drive(1'b1, 30);
    rstn = 1'b0;
    #2;
    checkOutput("t6Flags", {28'd0, pixel_valid, frame_end, err, dout}, 32'd0);
    checkOutput("t6Data", {8'd0, pixel_data}, 32'd0);
    checkOutput("t6Count", {16'd0, pixel_count}, 32'd0);
    din = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b0, 4);
    rstn = 1'b1;
    drive(1'b0, 100);
    r = $urandom;
    sendPixel(r[23:0], 1'b0, 1'b0, fh);
    drive(1'b0, 160);
    r = $urandom;
    sendPixel(r[23:0], 1'b0, 1'b1, fh);
    endFrame(1, 1'b0);
    checkQueues("t6");
    checkOutput("t6Err", errCount - e0, 32'd0);

    // Random frames: only pixels after the first are forwarded.
    for (int f = 0; f < 2; f++) begin
      e0 = errCount;
      doutHighCount = 0;
      expFwd = 0;
      n = int'($urandom_range(2, 1));
      for (int p = 0; p < n; p++) begin
        r = $urandom;
        sendPixel(r[23:0], 1'b0, 1'b1, fh);
        if (p > 0) expFwd += fh;
      end
      endFrame(n, 1'b0);
      checkQueues("rnd");
      checkOutput("rndDout", doutHighCount, expFwd);
      checkOutput("rndErr", errCount - e0, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
